// File: rtl/audio_out_buffer.sv
// rtl/audio_out_buffer.sv - sample FIFO between the effects chain and the AC97 output path
// Primes before playout, mutes on underrun, drops on overrun, and flushes when playback is low.
module audio_out_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  playback,
  input  logic                  sample_ready,
  input  logic [11:0]           sample_in,
  input  logic                  ac97_ready,
  output logic [11:0]           to_ac97_data,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  playing,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL      = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] PRIME_THR = PRIME_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] FILL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  typedef enum logic {PRIME, PLAY} state_t;

  state_t                  state;
  logic [11:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic                    pop;
  logic                    push;
  logic                    drop;

  // A pop frees a slot this cycle, so a write while full is still accepted alongside it.
  always_comb begin
    pop  = playback && (state == PLAY) && ac97_ready && (fill_level != '0);
    push = playback && sample_ready && ((fill_level != FULL) || pop);
    drop = playback && sample_ready && (fill_level == FULL) && !pop;
  end

  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fill_level   <= '0;
      to_ac97_data <= '0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      state        <= PRIME;
    end else if (!playback) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fill_level   <= '0;
      to_ac97_data <= '0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      state        <= PRIME;
    end else begin
      underrun <= 1'b0;
      overrun  <= drop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        to_ac97_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fill_level <= fill_level + FILL_ONE;
        2'b01:   fill_level <= fill_level - FILL_ONE;
        default: fill_level <= fill_level;
      endcase
      case (state)
        PRIME: begin
          if (fill_level >= PRIME_THR) begin
            state <= PLAY;
          end
        end
        PLAY: begin
          // Empty on a codec request: mute and fall back to priming.
          if (ac97_ready && (fill_level == '0)) begin
            to_ac97_data <= '0;
            underrun     <= 1'b1;
            state        <= PRIME;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

  assign playing = (state == PLAY);

endmodule

// File: tb/tb_audio_out_buffer.sv
// tb/tb_audio_out_buffer.sv - directed self-checking bench for audio_out_buffer
module tb_audio_out_buffer;

  logic        clock;
  logic        reset;
  logic        playback;
  logic        sample_ready;
  logic [11:0] sample_in;
  logic        ac97_ready;
  logic [11:0] to_ac97_data;
  logic [4:0]  fill_level;
  logic        playing;
  logic        underrun;
  logic        overrun;

  int compared;
  int mismatched;

  audio_out_buffer #(.DEPTH_LOG2(4), .PRIME_LEVEL(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .playback     (playback),
    .sample_ready (sample_ready),
    .sample_in    (sample_in),
    .ac97_ready   (ac97_ready),
    .to_ac97_data (to_ac97_data),
    .fill_level   (fill_level),
    .playing      (playing),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int data_s();
    return int'($signed(to_ac97_data));
  endfunction

  task automatic write(input int v);
    sample_ready = 1'b1;
    sample_in    = 12'(v);
    step();
    sample_ready = 1'b0;
  endtask

  task automatic request();
    ac97_ready = 1'b1;
    step();
    ac97_ready = 1'b0;
  endtask

  task automatic flush();
    playback = 1'b0;
    step();
    playback = 1'b1;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b0;
    playback     = 1'b0;
    sample_ready = 1'b0;
    sample_in    = '0;
    ac97_ready   = 1'b0;
    step();
    step();
    check("rst_data", data_s(), 0);
    check("rst_fill", fill_level, 0);
    check("rst_playing", playing, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    reset    = 1'b1;
    playback = 1'b1;

    // Basic prime and playout
    write(100);
    write(-200);
    write(300);
    write(-400);
    check("basic_fill4", fill_level, 4);
    check("basic_not_yet_playing", playing, 0);
    step();
    check("basic_playing", playing, 1);
    request(); check("basic_out0", data_s(), 100);
    step();    check("basic_hold0", data_s(), 100);
    request(); check("basic_out1", data_s(), -200);
    request(); check("basic_out2", data_s(), 300);
    request(); check("basic_out3", data_s(), -400);
    check("basic_fill0", fill_level, 0);
    check("basic_no_underrun", underrun, 0);

    // Flush mid-stream
    flush();
    check("flush_fill", fill_level, 0);
    check("flush_data", data_s(), 0);
    check("flush_playing", playing, 0);

    // Prime hold: three samples never start playout
    write(11);
    write(22);
    write(33);
    for (int i = 0; i < 5; i++) begin
      request();
      check("hold_data", data_s(), 0);
      check("hold_underrun", underrun, 0);
      check("hold_playing", playing, 0);
    end
    check("hold_fill", fill_level, 3);

    // Underrun with a coincident write
    flush();
    write(1);
    write(2);
    write(3);
    write(4);
    step();
    check("ur_playing", playing, 1);
    for (int i = 1; i <= 4; i++) begin
      request();
      check("ur_out", data_s(), i);
    end
    check("ur_no_pulse_yet", underrun, 0);
    sample_ready = 1'b1;
    sample_in    = 12'd50;
    request();
    sample_ready = 1'b0;
    check("ur_data_muted", data_s(), 0);
    check("ur_pulse", underrun, 1);
    check("ur_playing_drop", playing, 0);
    check("ur_fill", fill_level, 1);
    check("ur_no_overrun", overrun, 0);
    step();
    check("ur_pulse_end", underrun, 0);

    // Overrun
    flush();
    for (int i = 0; i < 16; i++) write(1000 + i);
    check("or_fill16", fill_level, 16);
    check("or_no_pulse", overrun, 0);
    write(1999);
    check("or_pulse", overrun, 1);
    check("or_fill_kept", fill_level, 16);
    step();
    check("or_pulse_end", overrun, 0);
    sample_ready = 1'b1;
    sample_in    = 12'd1500;
    request();
    sample_ready = 1'b0;
    check("or_pushpop_fill", fill_level, 16);
    check("or_pushpop_no_overrun", overrun, 0);
    check("or_pushpop_data", data_s(), 1000);

    // Wrap-around stream 0..39
    flush();
    for (int k = 0; k < 4; k++) write(k);
    step();
    for (int k = 4; k < 40; k++) begin
      sample_ready = 1'b1;
      sample_in    = 12'(k);
      ac97_ready   = 1'b1;
      step();
      check("wrap_out", data_s(), k - 4);
      check("wrap_fill", fill_level, 4);
    end
    sample_ready = 1'b0;
    ac97_ready   = 1'b0;
    for (int k = 36; k < 40; k++) begin
      request();
      check("wrap_drain", data_s(), k);
    end
    check("wrap_fill0", fill_level, 0);
    check("wrap_no_underrun", underrun, 0);

    // Reset during simultaneous push and pop
    for (int k = 0; k < 4; k++) write(70 + k);
    step();
    request();
    check("rs_pre_data", data_s(), 70);
    sample_ready = 1'b1;
    sample_in    = 12'd99;
    ac97_ready   = 1'b1;
    reset        = 1'b0;
    step();
    sample_ready = 1'b0;
    ac97_ready   = 1'b0;
    check("rs_data", data_s(), 0);
    check("rs_fill", fill_level, 0);
    check("rs_playing", playing, 0);
    check("rs_underrun", underrun, 0);
    check("rs_overrun", overrun, 0);
    reset = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
